// File: rtl/mdu.sv
// Iterative RV M-extension multiply/divide unit.
// Shift-add multiply, restoring divide, fast path for special cases.
module mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            z,
  output logic            err
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = '1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   rd_q, rd_d;
  logic              z_q, z_d;
  logic              err_q, err_d;

  logic            is_div, s1, s2, sa, sb;
  logic [XLEN-1:0] ma, mb;
  logic            illegal, b_zero, ovf, fast;
  logic [XLEN-1:0] fast_rd;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh, div_sub;
  logic            div_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rmd, res;

  // Accept-time decode: signedness, magnitudes and fast-path results.
  always_comb begin
    is_div  = funct3[2];
    s1      = !(funct3 inside {3'b011, 3'b101, 3'b111});
    s2      = funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
    sa      = s1 & rs1[XLEN-1];
    sb      = s2 & rs2[XLEN-1];
    ma      = sa ? -rs1 : rs1;
    mb      = sb ? -rs2 : rs2;
    illegal = funct7 != 7'h01;
    b_zero  = rs2 == '0;
    ovf     = (funct3 inside {3'b100, 3'b110})
              && rs1 == MIN && rs2 == ONES;
    fast    = illegal || (is_div && (b_zero || ovf));
    fast_rd = '0;
    if (illegal)
      fast_rd = '0;
    else if (b_zero)
      fast_rd = funct3[1] ? rs1 : ONES;
    else if (ovf)
      fast_rd = funct3[1] ? '0 : rs1;
  end

  // One iteration step and final sign fix-up / result select.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
            + (acc_q[0] ? {1'b0, b_q} : '0);
    div_sh  = {rem_q, acc_q[XLEN-1]};
    div_sub = div_sh - {1'b0, b_q};
    div_ge  = ~div_sub[XLEN];
    prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo     = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rmd     = sa_q ? -rem_q : rem_q;
    res     = '0;
    unique case (op_q)
      3'b000:                 res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res = quo;
      3'b110, 3'b111:         res = rmd;
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    b_d     = b_q;
    rd_d    = rd_q;
    z_d     = z_q;
    err_d   = err_q;
    if (flush) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d = funct3;
            sa_d = sa;
            sb_d = sb;
            if (fast) begin
              state_d = DONE;
              rd_d    = fast_rd;
              z_d     = fast_rd == '0;
              err_d   = illegal;
            end else begin
              state_d = CALC;
              cnt_d   = CNT_INIT;
              acc_d   = {{XLEN{1'b0}}, is_div ? ma : mb};
              rem_d   = '0;
              b_d     = is_div ? mb : ma;
              err_d   = 1'b0;
            end
          end
        end
        CALC: begin
          if (op_q[2]) begin
            acc_d = {acc_q[2*XLEN-1:XLEN],
                     acc_q[XLEN-2:0], div_ge};
            rem_d = div_ge ? div_sub[XLEN-1:0]
                           : div_sh[XLEN-1:0];
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE)
            state_d = FIX;
        end
        FIX: begin
          rd_d    = res;
          z_d     = res == '0;
          err_d   = 1'b0;
          state_d = DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            err_d   = 1'b0;
          end
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      rem_q   <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      z_q     <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      z_q     <= z_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign rd        = rd_q;
  assign z         = z_q;
  assign err       = err_q;

endmodule

// File: doc/mdu.md
# mdu

Parametrised iterative multiply/divide unit implementing the RV M-extension for the riscy_core execute stage, alongside `alu`. The execute stage hands it operands and `funct3`/`funct7` over a valid/ready handshake. It computes the product or quotient/remainder over multiple cycles and holds the result until the writeback side accepts it. Divide-by-zero and signed overflow follow the RISC-V spec and complete on a short fast path.

## Interface
- `XLEN`, 32, operand/result width; any even value ≥ 8.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `rs1`, `rs2`  in  XLEN  operands, sampled on accept.
- `funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `funct7`  in  7  must be 7'h01; any other value is illegal.
- `flush`  in  1  abort any in-flight operation.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `rd`  out  XLEN  result.
- `z`  out  1  high when `rd` == 0.
- `err`  out  1  high with `out_valid` when the accepted `funct7` ≠ 7'h01.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept: `in_valid && in_ready` at a rising edge. Operands, op, and signs are latched.
- IDLE→DONE fast path (result ready next edge) for:
  - illegal `funct7`: `rd`=0, `err`=1.
  - DIV/DIVU with `rs2`=0: quotient = all ones.
  - REM/REMU with `rs2`=0: remainder = `rs1`.
  - DIV with `rs1`=MIN (1 followed by XLEN-1 zeros) and `rs2`=all ones (-1): quotient = `rs1`.
  - REM with that same MIN, -1 pair: remainder = 0.
- IDLE→CALC otherwise; the iteration counter is loaded with XLEN.
- Operand signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: `rs1` signed, `rs2` unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Signed negative operands are converted to magnitude on accept.
- CALC, one iteration per cycle, counter decrements; CALC→FIX when the counter reaches 0 after XLEN iterations.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle, XLEN+1-bit partial remainder.
- FIX, one cycle, then → DONE:
  - Sign correction. Product is negated if operand signs differ. Quotient is negated if signs differ; remainder takes the sign of `rs1`.
  - Result selection: MUL = low XLEN bits, MULH* = high XLEN bits.
  - `rd` and `z` are registered.
- DONE: `out_valid`=1, `rd`/`z`/`err` stable. DONE→IDLE on `out_ready`.
- `in_ready` is low in DONE, so a new operation is accepted no earlier than the edge after the result handshake.
- `flush`, in any state: → IDLE at the next edge, `out_valid` drops, no result is produced. `flush` has priority over accept and over `out_ready`.
- `in_valid` is ignored when `in_ready`=0. Operand changes after accept have no effect.
- All arithmetic is modulo 2^XLEN; no exceptions are raised.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `rd`=0, `z`=1, `err`=0, counter 0.
- Reset asserted mid-operation discards the operation immediately (asynchronously).
- Normal latency: `out_valid` rises XLEN+2 edges after the accept edge (1 setup + XLEN CALC + 1 FIX). XLEN=32 gives 34.
- Fast-path latency: `out_valid` rises 1 edge after the accept edge.
- Throughput (normal ops): one operation per XLEN+3 cycles when `out_ready` is held high.
- Backpressure: DONE holds indefinitely with outputs stable while `out_ready`=0.
- `in_ready` falls on the accept edge and rises on the edge that completes the output handshake or flush.

## Test plan
- Multiply, XLEN=32:
  - MUL 7 × 0xFFFFFFFD → `rd`=0xFFFFFFEB, `z`=0.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
  - Each: `out_valid` exactly 34 edges after accept.
- Divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 20 / 3 → 6.
  - REMU 20 / 5 → 0 with `z`=1.
- Special cases, each with `out_valid` 1 edge after accept:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
  - `funct7`=7'h20 → `rd`=0, `err`=1.
- Handshake:
  - Hold `out_ready`=0 for 10 cycles after `out_valid` → `rd` stable, `in_ready`=0, `in_valid` ignored.
  - Raise `out_ready` → `in_ready` returns high on the next edge.
- Abort:
  - Assert `flush` in CALC cycle 10 → IDLE next edge, no `out_valid`; the next op (MUL 3×4) returns 12.
  - Assert `rst` mid-CALC → all outputs at reset values immediately.
- Parameter: XLEN=16, DIV 0xFFF9 / 2 → 0xFFFD with latency 18; MUL 0x0100 × 0x0100 → `rd`=0, `z`=1.
